shake256_squeeze: RTL
=====================

# shake256_squeeze

SHAKE256 squeeze-phase engine: it turns a fully absorbed 1600-bit Keccak state into an arbitrary-length output stream of 64-bit words.
- Accepts the post-absorb state (already XORed with padding and permuted) plus a requested word count.
- Streams the 136-byte rate portion out over a valid/ready interface.
- Asks the external KECCAK_f permutation for a fresh state each time the rate is exhausted.
- Sits between the absorb datapath and the downstream consumer of XOF output.

## Interface
- RATE_WORDS, 17: 64-bit words per rate block (1088 bits).
- LEN_W, 16: width of the requested-length counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  start-request pulse; sampled only in IDLE.
- state_in  in  1600  absorbed and permuted state. Byte i is at bits [1599-8i -: 8].
- out_len  in  LEN_W  number of 64-bit words to emit; sampled with load.
- busy  out  1  high in any state other than IDLE.
- perm_start  out  1  one-cycle request to the permutation core.
- perm_state  out  1600  state to be permuted; valid while perm_start is high and held until perm_done.
- perm_result  in  1600  permuted state; sampled when perm_done is high.
- perm_done  in  1  permutation complete.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  64  output word k = state bytes 8k..8k+7; byte 8k is in [63:56].
- out_last  out  1  marks the final requested word; qualified by out_valid.
- abort  in  1  present only with SHAKE256_SQZ_ABORT_EN.

## Operation
- Registers:
  - st: 1600-bit state.
  - idx: 0..RATE_WORDS-1.
  - rem: LEN_W-bit remaining-word count.
- FSM states: IDLE, EMIT, PERM_WAIT.
- IDLE:
  - load=1 with out_len≠0: st←state_in, idx←0, rem←out_len, go to EMIT.
  - load=1 with out_len=0: ignored.
- EMIT:
  - out_valid=1, out_data = st bytes [8·idx .. 8·idx+7], out_last = (rem==1).
  - Handshake (out_valid & out_ready) with rem==1: go to IDLE.
  - Handshake with idx==RATE_WORDS-1 and rem>1: rem−1, go to PERM_WAIT, perm_start=1 for exactly one cycle, perm_state=st.
  - Any other handshake: rem−1, idx+1.
- PERM_WAIT:
  - out_valid=0.
  - On perm_done: st←perm_result, idx←0, go to EMIT.
  - perm_done in any other state is ignored.
- load while busy is ignored; no queueing.
- Only the rate words are emitted. The capacity bits (st[511:0]) never appear on out_data.

## Timing
- Reset values: out_valid=0, out_last=0, busy=0, perm_start=0, out_data=0, perm_state=0. st, idx and rem are 0; FSM is in IDLE.
- Reset acts immediately and asynchronously. Asserting reset mid-EMIT or mid-PERM_WAIT discards the stream; a later perm_done is ignored.
- Latency: load sampled at edge N gives out_valid=1 from edge N+1.
- Throughput: one word per cycle while out_ready=1. The first word of each new block appears the cycle after perm_done is sampled.
- perm_start is asserted the cycle after the handshake of the 17th word of a block.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- out_valid never drops without a handshake, except on reset or abort.
- rem never underflows: reaching rem==1 plus a handshake always ends in IDLE.

## Configuration
- SHAKE256_SQZ_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in EMIT or PERM_WAIT: go to IDLE on the next edge, out_valid=0, rem←0, no further perm_start.
  - A perm_done that arrives after an abort is ignored.
  - abort in IDLE has no effect.
  - abort has priority over a simultaneous handshake; that word counts as not consumed.
- Not defined: no abort port. A stream ends only by completion or reset.

## Test plan
- Short stream: state_in bytes 0..135 = 0xA3, out_len=3, out_ready=1.
  - Expect 3 words of 0xA3A3A3A3A3A3A3A3, out_last on word 3.
  - busy falls the next cycle; perm_start never asserts.
- Exact block: state_in bytes = 0..135 (incrementing), out_len=17.
  - Word 0 = 0x0001020304050607, word 16 = 0x8081828384858687, out_last on word 16.
  - No perm_start.
- Block boundary: out_len=18, with perm_result (bytes 0..7 = 0x1122334455667788) returned 24 cycles after perm_start.
  - perm_start is a 1-cycle pulse after word 16, with perm_state = the loaded state.
  - Word 17 = 0x1122334455667788 with out_last.
- Backpressure: out_len=2, out_ready held low for 5 cycles.
  - out_valid=1 and out_data=word 0 stay unchanged for all 5 cycles.
  - Word 1 follows one cycle after out_ready rises.
- Reset mid-stream: reset driven low during word 5 of a 40-word stream.
  - All outputs go to 0 immediately.
  - After release, a new load with out_len=1 streams correctly.
- Abort (SHAKE256_SQZ_ABORT_EN): abort asserted in PERM_WAIT.
  - Expect IDLE next cycle; a later perm_done is ignored; out_valid stays 0.
  - A new load is accepted afterwards.

Source files
------------

// File: rtl/shake256_squeeze.sv
// SHAKE256 squeeze engine: streams the 17-word rate of an absorbed Keccak state and
// requests a fresh permutation per exhausted block. Optional abort port: SHAKE256_SQZ_ABORT_EN.
module shake256_squeeze #(
  parameter int RATE_WORDS = 17,
  parameter int LEN_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [1599:0]    state_in,
  input  logic [LEN_W-1:0] out_len,
  output logic             busy,
  output logic             perm_start,
  output logic [1599:0]    perm_state,
  input  logic [1599:0]    perm_result,
  input  logic             perm_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic [1:0]       dbg_state
`ifdef SHAKE256_SQZ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  // Output handshake: a word moves when out_valid and out_ready are both high on a
  // rising edge; out_data/out_last hold while out_valid is high and out_ready is low.

  localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EMIT      = 2'd1,
    S_PERM_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1599:0]      r_st;
  logic [IDX_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_rem;
  logic               r_perm_start;
  logic               w_abort;
  logic               w_start;
  logic               w_hs;
  logic               w_last_word;
  logic               w_block_end;
  logic [63:0]        w_word;
  logic [63:0]        w_rate_words [RATE_WORDS];

`ifdef SHAKE256_SQZ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Word k of the rate is bytes 8k..8k+7, with byte 8k landing in the top byte.
  for (genvar k = 0; k < RATE_WORDS; k++) begin : g_rate
    assign w_rate_words[k] = r_st[1599-64*k -: 64];
  end

  assign w_word      = w_rate_words[r_idx];
  assign w_start     = load && (out_len != '0);
  assign w_hs        = (r_state == S_EMIT) && out_ready && !w_abort;
  assign w_last_word = (r_rem == REM_ONE);
  assign w_block_end = (r_idx == LAST_IDX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    perm_state  = '0;
    busy        = (r_state != S_IDLE);
    perm_start  = r_perm_start;
    dbg_state   = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = w_last_word;
        out_data  = w_word;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          if (w_last_word)      w_state_nxt = S_IDLE;
          else if (w_block_end) w_state_nxt = S_PERM_WAIT;
        end
      end
      S_PERM_WAIT: begin
        // st is frozen here, so it doubles as the held permutation operand.
        perm_state = r_st;
        if (w_abort)        w_state_nxt = S_IDLE;
        else if (perm_done) w_state_nxt = S_EMIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st         <= '0;
      r_idx        <= '0;
      r_rem        <= '0;
      r_perm_start <= 1'b0;
    end else begin
      r_perm_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_st  <= state_in;
            r_idx <= '0;
            r_rem <= out_len;
          end
        end
        S_EMIT: begin
          if (w_abort) begin
            r_rem <= '0;
          end else if (w_hs) begin
            r_rem <= r_rem - REM_ONE;
            if (!w_last_word) begin
              if (w_block_end) r_perm_start <= 1'b1;
              else             r_idx <= r_idx + IDX_ONE;
            end
          end
        end
        S_PERM_WAIT: begin
          if (w_abort) begin
            r_rem <= '0;
          end else if (perm_done) begin
            r_st  <= perm_result;
            r_idx <= '0;
          end
        end
        default: begin
          r_rem <= '0;
        end
      endcase
    end
  end

endmodule
